uart_var_frame_tx: RTL
======================

UART_VAR_FRAME_TX -- requirements
Module: uart_var_frame_tx

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4, payload bytes per frame (legal 1..255).
REQ-002 SHALL have parameter HEADER, default 8'hA5, frame start byte.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port frame_data, input, 8*DATA_BYTES, payload; most significant byte is sent first.
REQ-006 SHALL have port frame_cmd, input, 8, command byte.
REQ-007 SHALL have port frame_valid, input, 1, frame request.
REQ-008 SHALL have port frame_ready, output, 1, frame accept.
REQ-009 SHALL have port frame_done, output, 1, one-cycle pulse after the last byte completes.
REQ-010 SHALL have port tx_data, output, 8, byte presented to the byte transmitter.
REQ-011 SHALL have port tx_start, output, 1, one-cycle byte start strobe.
REQ-012 SHALL have port tx_done, input, 1, byte-complete pulse from the byte transmitter.
REQ-013 SHALL have port tx_idle, input, 1, byte transmitter idle level.

Function
REQ-014 Frame order SHALL be: HEADER, CMD, LEN (=DATA_BYTES), payload bytes MSB first, CHK; total DATA_BYTES+4 bytes.
REQ-015 CHK SHALL be the 8-bit XOR of CMD, LEN and all payload bytes; HEADER is excluded.
REQ-016 frame_ready SHALL be 1 only in IDLE; a frame is accepted on a clock where frame_valid=1 and frame_ready=1.
REQ-017 On acceptance, frame_cmd and frame_data SHALL be captured; later input changes SHALL NOT affect the frame in flight.
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-019 IDLE->ISSUE on acceptance; byte index cleared; checksum accumulator cleared.
REQ-020 ISSUE: while tx_idle=0, the FSM SHALL hold; when tx_idle=1, it SHALL assert tx_start for exactly one cycle and go to WAIT.
REQ-021 tx_data SHALL be valid in the tx_start cycle and held stable until the matching tx_done.
REQ-022 WAIT: on tx_done=1, the FSM SHALL fold the sent byte into the checksum if applicable and increment the index; it SHALL go to DONE if the index was DATA_BYTES+3, else to ISSUE.
REQ-023 tx_done SHALL be ignored in IDLE, ISSUE and DONE.
REQ-024 DONE SHALL assert frame_done for one cycle, then return to IDLE; frame_ready SHALL rise the following cycle.
REQ-025 A frame_valid held high continuously SHALL yield back-to-back frames with one IDLE cycle between them.
REQ-026 The minimum latency from acceptance to the first tx_start SHALL be 1 cycle when tx_idle=1.
REQ-027 The byte index width SHALL be clog2(DATA_BYTES+4); there is no wrap within a frame.

Reset
REQ-028 Reset SHALL force the state to IDLE with frame_ready=1, frame_done=0, tx_start=0, tx_data=8'h00, index=0 and checksum=0.
REQ-029 Reset mid-frame SHALL abandon the frame without emitting frame_done; a byte already in the byte transmitter completes externally and its tx_done is ignored.
REQ-030 Reset deassertion SHALL be assumed synchronous to clk by the system integrator.

Structure
REQ-031 State encodings and the default HEADER value SHALL live in the shared uart_var package/include for reuse by the matching frame receiver.
REQ-032 No sub-module is required; the block drives the byte interface of uart_var (tx_data, tx_start, tx_done, tx_idle) directly.

Verification
REQ-033 DATA_BYTES=4, cmd=8'h12, data=32'h01020304, tx_idle=1 with tx_done 10 cycles after each start -> bytes A5,12,04,01,02,03,04,12, then one frame_done pulse.
REQ-034 tx_idle held 0 for 20 cycles after acceptance -> no tx_start until tx_idle=1; then tx_start is a single-cycle pulse.
REQ-035 frame_valid toggled and frame_data changed mid-frame -> no new acceptance; the original bytes are sent unchanged.
REQ-036 rst asserted low after the third tx_done -> tx_start=0 and frame_ready=1 immediately; no frame_done; a stray tx_done is ignored; the next frame starts with A5.
REQ-037 frame_valid held high, two frames, DATA_BYTES=1, data=8'hFF, cmd=8'h00 -> each frame sends A5,00,01,FF,FE; exactly one IDLE cycle separates the frames.
REQ-038 Spurious tx_done while in IDLE -> no state change, no output change.

Source files
------------

// File: rtl/uart_var_pkg.sv
// Shared definitions for the uart_var frame transmitter and its matching receiver.
package uart_var_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } uart_var_state_e;

    localparam logic [7:0] UART_VAR_HEADER = 8'hA5;

endpackage

// File: rtl/uart_var_frame_tx.sv
// Frame sequencer for the uart_var byte transmitter: sends HEADER, CMD, LEN,
// payload (MSB first) and an XOR checksum, one byte per tx_start/tx_done handshake.
module uart_var_frame_tx
    import uart_var_pkg::*;
#(
    parameter int         DATA_BYTES = 4,
    parameter logic [7:0] HEADER     = UART_VAR_HEADER
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*DATA_BYTES-1:0] frame_data,
    input  logic [7:0]              frame_cmd,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    output logic                    frame_done,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    input  logic                    tx_done,
    input  logic                    tx_idle
);

    localparam int                 IDX_W    = $clog2(DATA_BYTES + 4);
    localparam int                 PW       = 8 * DATA_BYTES;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DATA_BYTES + 3);
    localparam logic [7:0]         LEN      = 8'(DATA_BYTES);

    uart_var_state_e  state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       chk_q, chk_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [PW-1:0]    data_q, data_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             frame_ready_q, frame_ready_d;
    logic             frame_done_q, frame_done_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        chk_d     = chk_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        tx_data_d = tx_data_q;

        case (state_q)
            ST_IDLE: begin
                if (frame_valid) begin
                    state_d   = ST_ISSUE;
                    idx_d     = '0;
                    chk_d     = '0;
                    cmd_d     = frame_cmd;
                    data_d    = frame_data;
                    tx_data_d = HEADER;
                end
            end
            ST_ISSUE: begin
                if (tx_idle) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tx_done) begin
                    // HEADER (index 0) and CHK itself stay out of the checksum.
                    if (idx_q != '0 && idx_q != LAST_IDX) begin
                        chk_d = chk_q ^ tx_data_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        idx_d   = idx_q + IDX_W'(1);
                        if (idx_d == IDX_W'(1)) begin
                            tx_data_d = cmd_q;
                        end else if (idx_d == IDX_W'(2)) begin
                            tx_data_d = LEN;
                        end else if (idx_d == LAST_IDX) begin
                            tx_data_d = chk_d;
                        end else begin
                            // Payload leaves from the top of a left-shifting copy.
                            tx_data_d = data_q[PW-1 -: 8];
                            data_d    = data_q << 8;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        frame_ready_d = (state_d == ST_IDLE);
        frame_done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            chk_q         <= '0;
            cmd_q         <= '0;
            data_q        <= '0;
            tx_data_q     <= '0;
            frame_ready_q <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q       <= state_d;
            idx_q         <= idx_d;
            chk_q         <= chk_d;
            cmd_q         <= cmd_d;
            data_q        <= data_d;
            tx_data_q     <= tx_data_d;
            frame_ready_q <= frame_ready_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // Decoded from state so the first start can land in the cycle right after acceptance.
    assign tx_start    = (state_q == ST_ISSUE) && tx_idle;
    assign tx_data     = tx_data_q;
    assign frame_ready = frame_ready_q;
    assign frame_done  = frame_done_q;

endmodule
